vend_dispense_arbiter: RTL

Arbitrates dispense requests from the cash and credit front ends onto the machine's single dispense motor and coin-return chute. It tracks per-slot inventory, sequences the timed motor pulse and the quarter-by-quarter change pulses, and returns a one-cycle acknowledge with status to the winning requester. It sits between the vending FSMs and the physical actuators, so neither front end drives `motor` or `coin_out` directly.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/dispense_timer.sv | 26 ++
 rtl/vend_dispense_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared states, sizes and helpers for the dispense arbiter
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHG_HI = 3'd3,
    ST_CHG_LO = 3'd4,
    ST_DONE   = 3'd5
  } vend_state_e;

  localparam int NUM_SLOTS = 8;
  localparam int CASH      = 0;
  localparam int CREDIT    = 1;

  function automatic logic is_onehot(input logic [NUM_SLOTS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [NUM_SLOTS-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// rtl/dispense_timer.sv - loadable down-counter; done marks the last cycle of an interval
module dispense_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/vend_dispense_arbiter.sv
// rtl/vend_dispense_arbiter.sv - arbitrates cash/credit vends onto motor and coin chute
// Optional restock port and reload behaviour under VEND_RESTOCK_EN.
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int VEND_CYC  = 25,
  parameter int PULSE_CYC = 4,
  parameter int INV_W     = 4,
  parameter int INV_INIT  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [7:0] item0,
  input  logic [7:0] item1,
  input  logic [3:0] chg0,
  input  logic [3:0] chg1,
  output logic [1:0] ack,
  output logic       empty,
  output logic       err,
  output logic       motor,
  output logic       coin_out,
  output logic       busy,
  output logic [2:0] state
`ifdef VEND_RESTOCK_EN
  ,
  input  logic       restock
`endif
);

  localparam int TMAX = (VEND_CYC > PULSE_CYC) ? VEND_CYC : PULSE_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  vend_state_e st, nxt;

  logic             grant, last_grant, pick;
  logic [7:0]       item_q;
  logic [3:0]       chg_q;
  logic             empty_q, err_q;
  logic [INV_W-1:0] inv [NUM_SLOTS];
  logic [2:0]       slot_idx;

  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;
  logic          take, dec_inv, dec_chg, set_err, set_empty, finish;
  logic          restock_now;

`ifdef VEND_RESTOCK_EN
  assign restock_now = restock && (st == ST_IDLE);
`else
  assign restock_now = 1'b0;
`endif

  // A tie goes to whoever was not served last; a lone request always wins.
  assign pick     = (req == 2'b11) ? ~last_grant : req[1];
  assign slot_idx = onehot_idx(item_q);

  dispense_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt       = st;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    take      = 1'b0;
    dec_inv   = 1'b0;
    dec_chg   = 1'b0;
    set_err   = 1'b0;
    set_empty = 1'b0;
    finish    = 1'b0;
    case (st)
      ST_IDLE: begin
        if (!restock_now && (req != 2'b00)) begin
          take = 1'b1;
          nxt  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!is_onehot(item_q)) begin
          set_err = 1'b1;
          nxt     = ST_DONE;
        end else if (inv[slot_idx] == '0) begin
          set_empty = 1'b1;
          nxt       = ST_DONE;
        end else begin
          dec_inv  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TW'(VEND_CYC);
          nxt      = ST_VEND;
        end
      end
      ST_VEND: begin
        if (tmr_done) begin
          if (chg_q == 4'd0) begin
            nxt = ST_DONE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = TW'(PULSE_CYC);
            nxt      = ST_CHG_HI;
          end
        end
      end
      ST_CHG_HI: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYC);
          nxt      = ST_CHG_LO;
        end
      end
      ST_CHG_LO: begin
        if (tmr_done) begin
          dec_chg = 1'b1;
          if (chg_q != 4'd1) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(PULSE_CYC);
            nxt      = ST_CHG_HI;
          end else begin
            nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        finish = 1'b1;
        nxt    = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant      <= 1'b0;
      last_grant <= 1'(CREDIT);
      item_q     <= '0;
      chg_q      <= '0;
      empty_q    <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) inv[i] <= INV_W'(INV_INIT);
    end else begin
      if (restock_now) begin
        for (int i = 0; i < NUM_SLOTS; i++) inv[i] <= INV_W'(INV_INIT);
      end
      if (take) begin
        grant  <= pick;
        item_q <= pick ? item1 : item0;
        chg_q  <= pick ? chg1 : chg0;
      end
      if (dec_inv)   inv[slot_idx] <= inv[slot_idx] - 1'b1;
      if (dec_chg)   chg_q <= chg_q - 4'd1;
      if (set_err)   err_q <= 1'b1;
      if (set_empty) empty_q <= 1'b1;
      if (finish) begin
        last_grant <= grant;
        err_q      <= 1'b0;
        empty_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    ack = 2'b00;
    if (st == ST_DONE) ack[grant] = 1'b1;
  end

  assign empty    = (st == ST_DONE) && empty_q;
  assign err      = (st == ST_DONE) && err_q;
  assign motor    = (st == ST_VEND);
  assign coin_out = (st == ST_CHG_HI);
  assign busy     = (st != ST_IDLE);
  assign state    = st;

endmodule
